// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the serial chunk adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_n(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Index counter width; never narrower than one bit, even for a single step.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit ripple of full adders; also reports the carry entering its MSB.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[CHUNK];
  // With CHUNK=1 this is simply cin, i.e. the carry register entering the step.
  assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle add/subtract: one CHUNK-bit slice reused LSB-first with a registered carry.
module serial_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output state_t           dbg_state
);

  localparam int N  = calc_n(WIDTH, CHUNK);
  localparam int IW = idx_width(N);

  if ((WIDTH % CHUNK) != 0) begin : g_width_check
    $error("serial_chunk_adder: WIDTH must be a multiple of CHUNK");
  end

  // Handshake: start is taken on any rising edge where busy=0 (IDLE or DONE);
  // done is high for exactly the one cycle after the final chunk edge, and
  // sum/cout/ovf only change on that same edge.
  state_t state, state_n;
  logic   load;
  logic   last;

  logic [N-1:0][CHUNK-1:0] a_q, b_q, psum, psum_n;
  logic [IW-1:0]           idx;
  logic                    carry;

  logic [CHUNK-1:0] slice_s;
  logic             slice_cout;
  logic             slice_cmsb;

  assign last = (idx == IW'(N - 1));

  chunk_adder #(.CHUNK(CHUNK)) u_slice (
    .a    (a_q[idx]),
    .b    (b_q[idx]),
    .cin  (carry),
    .s    (slice_s),
    .cout (slice_cout),
    .cmsb (slice_cmsb)
  );

  always_comb begin
    psum_n      = psum;
    psum_n[idx] = slice_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = RUN;
          load    = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      RUN:     if (last) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      psum  <= '0;
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      // Subtraction is a + ~b + 1, so the inversion and the +1 are folded in here.
      a_q   <= a;
      b_q   <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
      idx   <= '0;
    end else if (state == RUN) begin
      psum  <= psum_n;
      carry <= slice_cout;
      if (last) begin
        sum  <= psum_n;
        cout <= slice_cout;
        ovf  <= slice_cmsb ^ slice_cout;
      end else begin
        idx <= idx + IW'(1);
      end
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Self-checking bench: three instances (CHUNK = 1, 4, 16) against an arithmetic reference model.
module tb_serial_chunk_adder;
  import adder_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [2:0]  start;
  logic        sub;
  logic        cin;
  logic [15:0] a;
  logic [15:0] b;

  logic        busy_w [3];
  logic        done_w [3];
  logic        cout_w [3];
  logic        ovf_w  [3];
  logic [15:0] sum_w  [3];
  state_t      st_w   [3];

  int          nval [3] = '{16, 4, 1};
  int          errors = 0;
  int          checks = 0;
  logic [17:0] exp_q [$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  serial_chunk_adder #(.WIDTH(16), .CHUNK(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy_w[0]), .done(done_w[0]), .sum(sum_w[0]), .cout(cout_w[0]), .ovf(ovf_w[0]),
    .dbg_state(st_w[0])
  );

  serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy_w[1]), .done(done_w[1]), .sum(sum_w[1]), .cout(cout_w[1]), .ovf(ovf_w[1]),
    .dbg_state(st_w[1])
  );

  serial_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_c16 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy_w[2]), .done(done_w[2]), .sum(sum_w[2]), .cout(cout_w[2]), .ovf(ovf_w[2]),
    .dbg_state(st_w[2])
  );

  // ---------------- reference model ----------------
  // Returns {ovf, cout, sum} from plain 17-bit arithmetic and operand signs.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic s, input logic ci);
    logic [15:0] yy;
    logic [16:0] t;
    logic        o;
    yy = s ? ~y : y;
    t  = {1'b0, x} + {1'b0, yy} + 17'(s ? 1'b1 : ci);
    o  = (x[15] == yy[15]) && (t[15] != x[15]);
    return {o, t[16], t[15:0]};
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] res_of(input int i);
    return {ovf_w[i], cout_w[i], sum_w[i]};
  endfunction

  // ---------------- driver: one operation on the masked instances ----------------
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic ts,
                        input logic tc, input logic [2:0] mask, input logic [17:0] exp,
                        input string tag);
    int lat  [3];
    bit seen [3];
    @(negedge clk);
    a = ta; b = tb_; sub = ts; cin = tc; start = mask;
    @(negedge clk);
    start = '0;
    a     = 16'($urandom);
    b     = 16'($urandom);
    sub   = 1'($urandom_range(0, 1));
    cin   = 1'($urandom_range(0, 1));
    for (int i = 0; i < 3; i++) begin
      seen[i] = 1'b0;
      lat[i]  = 0;
    end
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (mask[i]) begin
          if (seen[i] && cyc == lat[i] + 1)
            chk($sformatf("%s_c%0d_pulse", tag, i), 32'(done_w[i]), 32'd0);
          if (!seen[i] && done_w[i]) begin
            seen[i] = 1'b1;
            lat[i]  = cyc;
            chk($sformatf("%s_c%0d_res", tag, i), 32'(res_of(i)), 32'(exp));
          end
        end
      end
    end
    for (int i = 0; i < 3; i++)
      if (mask[i]) chk($sformatf("%s_c%0d_lat", tag, i), 32'(lat[i]), 32'(nval[i]));
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    logic [15:0] ra, rb;
    logic        rs, rc;
    logic        exp_done;

    rst_n = 1'b0; start = '0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_c%0d_outs", i),
          32'({busy_w[i], done_w[i], ovf_w[i], cout_w[i], sum_w[i]}), 32'd0);
      chk($sformatf("rst_c%0d_state", i), 32'(st_w[i]), 32'(IDLE));
    end
    rst_n = 1'b1;

    run_op(16'h0001, 16'h0006, 1'b0, 1'b0, 3'b111, {1'b0, 1'b0, 16'h0007}, "add");
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 3'b111, {1'b0, 1'b1, 16'h0000}, "wrap");
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 3'b111, {1'b1, 1'b0, 16'h8000}, "sovf");
    run_op(16'h0005, 16'h0007, 1'b1, 1'b0, 3'b111, {1'b0, 1'b0, 16'hFFFE}, "sub");
    run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 3'b111, {1'b1, 1'b1, 16'h7FFF}, "subovf");
    run_op(16'h1000, 16'h2000, 1'b0, 1'b1, 3'b111, {1'b0, 1'b0, 16'h3001}, "addcin");

    // start pulsed mid-RUN with other operands must be ignored (CHUNK=4 only)
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; sub = 1'b0; cin = 1'b0; start[1] = 1'b1;
    @(negedge clk); start[1] = 1'b0;
    @(negedge clk);
    @(negedge clk); start[1] = 1'b1; a = 16'hFFFF; b = 16'h0001; sub = 1'b1;
    @(negedge clk); start[1] = 1'b0;
    @(negedge clk);
    chk("midstart_done", 32'(done_w[1]), 32'd1);
    chk("midstart_res", 32'(res_of(1)), 32'({1'b0, 1'b0, 16'h2345}));
    @(negedge clk);
    chk("midstart_idle", 32'({busy_w[1], done_w[1]}), 32'd0);

    // start held high: a new operation is taken in every DONE cycle
    exp_q.delete();
    @(negedge clk);
    a = 16'h00FF; b = 16'h0F01; sub = 1'b0; cin = 1'b0; start[1] = 1'b1;
    exp_q.push_back(model(a, b, sub, cin));
    @(negedge clk);
    a = 16'h0100; b = 16'h0200; sub = 1'b1;
    exp_q.push_back(model(a, b, sub, cin));
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      exp_done = (cyc == 4) || (cyc == 9) || (cyc == 14);
      chk($sformatf("held_done_%0d", cyc), 32'(done_w[1]), 32'(exp_done));
      chk($sformatf("held_busy_%0d", cyc), 32'(busy_w[1]), 32'(!exp_done));
      if (done_w[1]) begin
        if (exp_q.size() > 0) chk($sformatf("held_res_%0d", cyc), 32'(res_of(1)), 32'(exp_q.pop_front()));
        else                  chk("held_extra_done", 32'(done_w[1]), 32'd0);
      end
      if (cyc == 5) begin
        a = 16'h7000; b = 16'h1000; sub = 1'b0; cin = 1'b1;
        exp_q.push_back(model(a, b, sub, cin));
      end
      if (cyc == 10) start[1] = 1'b0;
    end
    chk("held_drain", 32'(exp_q.size()), 32'd0);

    // asynchronous reset during the second RUN cycle
    @(negedge clk);
    a = 16'hABCD; b = 16'h1111; sub = 1'b0; cin = 1'b0; start = 3'b011;
    @(negedge clk); start = '0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("arst_c%0d_outs", i),
          32'({busy_w[i], done_w[i], ovf_w[i], cout_w[i], sum_w[i]}), 32'd0);
      chk($sformatf("arst_c%0d_state", i), 32'(st_w[i]), 32'(IDLE));
    end
    @(negedge clk); rst_n = 1'b1;
    run_op(16'h4321, 16'h1234, 1'b1, 1'b0, 3'b111, model(16'h4321, 16'h1234, 1'b1, 1'b0), "postrst");

    // random operands, both modes, all three chunk sizes
    for (int k = 0; k < 20; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      run_op(ra, rb, rs, rc, 3'b111, model(ra, rb, rs, rc), $sformatf("rand%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
